// File: rtl/count_recorder_if.sv
// Capture buffer bus: sample input, clear/arm controls, read port and status.
// master drives controls/samples/reads; slave is the recorder.
interface count_recorder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic                  clr;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [ADDR_WIDTH:0]   level;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  end_pulse;
    logic                  capturing;

    modport master (
        output start, clr, in_valid, in_data, rd_req,
        input  rd_data, rd_valid, level, full, empty,
        input  overflow, end_pulse, capturing
    );

    modport slave (
        input  start, clr, in_valid, in_data, rd_req,
        output rd_data, rd_valid, level, full, empty,
        output overflow, end_pulse, capturing
    );
endinterface

// File: rtl/count_recorder.sv
// Circular capture buffer for counter samples; stops after the all-ones sample.
// COUNT_RECORDER_OVERWRITE_EN: writes while full replace the oldest entry.
module count_recorder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    count_recorder_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LVL_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_STOPPED = 2'd2;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_end;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_last;
    logic w_rd;
    logic w_push;
    logic w_evict;

    assign w_full   = (r_level == LVL_FULL);
    assign w_empty  = (r_level == '0);
    assign w_accept = !bus.clr && (r_state == S_CAPTURE) && bus.in_valid;
    assign w_last   = w_accept && (bus.in_data == ALL_ONES);
    assign w_rd     = !bus.clr && bus.rd_req && !w_empty;

`ifdef COUNT_RECORDER_OVERWRITE_EN
    // Full with no read: write over the oldest slot and drop it.
    assign w_push  = w_accept;
    assign w_evict = w_accept && w_full && !w_rd;
`else
    assign w_push  = w_accept && (!w_full || w_rd);
    assign w_evict = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (bus.clr) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (bus.start) r_state <= S_CAPTURE;
                S_CAPTURE: if (w_last) r_state <= S_STOPPED;
                S_STOPPED: r_state <= S_STOPPED;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_end      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (bus.clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_end      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_end      <= w_last;
            r_rd_valid <= w_rd;
            if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd || w_evict) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_accept && w_full && !w_rd) r_overflow <= 1'b1;
            if (w_push && !w_rd && !w_evict) r_level <= r_level + LVL_ONE;
            else if (w_rd && !w_push) r_level <= r_level - LVL_ONE;
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.level     = r_level;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.overflow  = r_overflow;
    assign bus.end_pulse = r_end;
    assign bus.capturing = (r_state == S_CAPTURE);
endmodule

// File: tb/tb_count_recorder.sv
// Directed bench for count_recorder: reset, capture/drain, end of count,
// full handling, simultaneous read/write, clear and asynchronous reset.
module tb_count_recorder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

`ifdef COUNT_RECORDER_OVERWRITE_EN
    localparam int FULL_OFS = 4;
`else
    localparam int FULL_OFS = 0;
`endif

    count_recorder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    count_recorder #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wr(input logic [7:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic rd();
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++; if (bus.rd_data !== 8'd0) begin n_errors++; $display("FAIL rst_rd_data got %0d want 0", bus.rd_data); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rd_valid got %0b want 0", bus.rd_valid); end
        n_checks++; if (bus.level !== 5'd0) begin n_errors++; $display("FAIL rst_level got %0d want 0", bus.level); end
        n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL rst_full got %0b want 0", bus.full); end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL rst_empty got %0b want 1", bus.empty); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL rst_overflow got %0b want 0", bus.overflow); end
        n_checks++; if (bus.end_pulse !== 1'b0) begin n_errors++; $display("FAIL rst_end_pulse got %0b want 0", bus.end_pulse); end
        n_checks++; if (bus.capturing !== 1'b0) begin n_errors++; $display("FAIL rst_capturing got %0b want 0", bus.capturing); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_clr();
        // Sample presented with start is not yet accepted.
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.level !== 5'd0) begin n_errors++; $display("FAIL start_edge_level got %0d want 0", bus.level); end
        n_checks++; if (bus.capturing !== 1'b1) begin n_errors++; $display("FAIL basic_capturing got %0b want 1", bus.capturing); end
        for (int i = 0; i < 10; i++) wr(8'(i));
        n_checks++; if (bus.level !== 5'd10) begin n_errors++; $display("FAIL basic_level got %0d want 10", bus.level); end
        for (int i = 0; i < 10; i++) begin
            rd();
            n_checks++; if (bus.rd_valid !== 1'b1) begin n_errors++; $display("FAIL basic_rd_valid[%0d] got %0b want 1", i, bus.rd_valid); end
            n_checks++; if (bus.rd_data !== 8'(i)) begin n_errors++; $display("FAIL basic_rd_data[%0d] got %0d want %0d", i, bus.rd_data, i); end
            tick();
            n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL basic_rd_pulse[%0d] got %0b want 0", i, bus.rd_valid); end
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL basic_empty got %0b want 1", bus.empty); end
        rd();
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL empty_rd_valid got %0b want 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 8'd9) begin n_errors++; $display("FAIL empty_rd_hold got %0d want 9", bus.rd_data); end
    endtask

    task automatic test_end_of_count();
        do_clr();
        do_start();
        for (int v = 250; v < 255; v++) wr(8'(v));
        n_checks++; if (bus.end_pulse !== 1'b0) begin n_errors++; $display("FAIL end_early got %0b want 0", bus.end_pulse); end
        wr(8'd255);
        n_checks++; if (bus.end_pulse !== 1'b1) begin n_errors++; $display("FAIL end_pulse got %0b want 1", bus.end_pulse); end
        n_checks++; if (bus.capturing !== 1'b0) begin n_errors++; $display("FAIL end_capturing got %0b want 0", bus.capturing); end
        wr(8'd0);
        n_checks++; if (bus.end_pulse !== 1'b0) begin n_errors++; $display("FAIL end_pulse_width got %0b want 0", bus.end_pulse); end
        n_checks++; if (bus.level !== 5'd6) begin n_errors++; $display("FAIL end_level got %0d want 6", bus.level); end
        do_start();
        wr(8'd1);
        n_checks++; if (bus.level !== 5'd6) begin n_errors++; $display("FAIL stopped_start got %0d want 6", bus.level); end
    endtask

    task automatic test_full();
        do_clr();
        do_start();
        for (int i = 0; i < 20; i++) wr(8'(i));
        n_checks++; if (bus.full !== 1'b1) begin n_errors++; $display("FAIL full_flag got %0b want 1", bus.full); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL full_overflow got %0b want 1", bus.overflow); end
        n_checks++; if (bus.level !== 5'd16) begin n_errors++; $display("FAIL full_level got %0d want 16", bus.level); end
        for (int i = 0; i < 16; i++) begin
            rd();
            n_checks++; if (bus.rd_data !== 8'(i + FULL_OFS)) begin n_errors++; $display("FAIL full_drain[%0d] got %0d want %0d", i, bus.rd_data, i + FULL_OFS); end
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL full_empty got %0b want 1", bus.empty); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL full_sticky got %0b want 1", bus.overflow); end
    endtask

    task automatic test_simultaneous();
        do_clr();
        do_start();
        for (int i = 0; i < 16; i++) wr(8'(i));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd16;
        bus.rd_req   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.rd_req   = 1'b0;
        n_checks++; if (bus.rd_valid !== 1'b1) begin n_errors++; $display("FAIL rw_full_valid got %0b want 1", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 8'd0) begin n_errors++; $display("FAIL rw_full_data got %0d want 0", bus.rd_data); end
        n_checks++; if (bus.level !== 5'd16) begin n_errors++; $display("FAIL rw_full_level got %0d want 16", bus.level); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL rw_full_overflow got %0b want 0", bus.overflow); end
        for (int i = 0; i < 16; i++) begin
            rd();
            n_checks++; if (bus.rd_data !== 8'(i + 1)) begin n_errors++; $display("FAIL rw_drain[%0d] got %0d want %0d", i, bus.rd_data, i + 1); end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd77;
        bus.rd_req   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.rd_req   = 1'b0;
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL rw_empty_valid got %0b want 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 8'd16) begin n_errors++; $display("FAIL rw_empty_hold got %0d want 16", bus.rd_data); end
        n_checks++; if (bus.level !== 5'd1) begin n_errors++; $display("FAIL rw_empty_level got %0d want 1", bus.level); end
        for (int i = 0; i < 15; i++) wr(8'(i));
        wr(8'd200);
        n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL pre_clr_overflow got %0b want 1", bus.overflow); end
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd5;
        tick();
        bus.clr = 1'b0;
        n_checks++; if (bus.level !== 5'd0) begin n_errors++; $display("FAIL clr_level got %0d want 0", bus.level); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL clr_overflow got %0b want 0", bus.overflow); end
        n_checks++; if (bus.capturing !== 1'b0) begin n_errors++; $display("FAIL clr_capturing got %0b want 0", bus.capturing); end
        n_checks++; if (bus.rd_data !== 8'd16) begin n_errors++; $display("FAIL clr_rd_hold got %0d want 16", bus.rd_data); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.level !== 5'd0) begin n_errors++; $display("FAIL idle_ignore got %0d want 0", bus.level); end
    endtask

    task automatic test_reset_mid();
        do_clr();
        do_start();
        for (int i = 10; i < 15; i++) wr(8'(i));
        rd();
        n_checks++; if (bus.level !== 5'd4) begin n_errors++; $display("FAIL mid_level got %0d want 4", bus.level); end
        wr(8'd15);
        n_checks++; if (bus.level !== 5'd5) begin n_errors++; $display("FAIL mid_level5 got %0d want 5", bus.level); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.level !== 5'd0) begin n_errors++; $display("FAIL arst_level got %0d want 0", bus.level); end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL arst_empty got %0b want 1", bus.empty); end
        n_checks++; if (bus.rd_data !== 8'd0) begin n_errors++; $display("FAIL arst_rd_data got %0d want 0", bus.rd_data); end
        n_checks++; if (bus.capturing !== 1'b0) begin n_errors++; $display("FAIL arst_capturing got %0b want 0", bus.capturing); end
        #1;
        rst = 1'b0;
        wr(8'd33);
        n_checks++; if (bus.level !== 5'd0) begin n_errors++; $display("FAIL arst_idle got %0d want 0", bus.level); end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        bus.start    = 1'b0;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_req   = 1'b0;
        test_reset();
        test_basic();
        test_end_of_count();
        test_full();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/count_recorder.md
# count_recorder

Capture buffer directly downstream of the free-running 8-bit counter in the simulation top. Samples are armed by `start`, qualified by `in_valid`, and stored in a 16-entry circular buffer. Capture stops after the all-ones sample (255), and a one-cycle end pulse marks it, mirroring the `counter_end` event. A testbench or Verisocks client drains the stored history through a registered read port.

## Interface
Parameters:
- `DATA_WIDTH`, 8: sample width.
- `ADDR_WIDTH`, 4: log2 of buffer depth; depth = 2^ADDR_WIDTH = 16.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: arms capture; honoured in IDLE only.
- `clr`  in  1: synchronous clear; has priority over every other input.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_data`  in  DATA_WIDTH: counter sample.
- `rd_req`  in  1: pop one entry.
- `rd_data`  out  DATA_WIDTH: popped entry; registered.
- `rd_valid`  out  1: `rd_data` is valid; one-cycle pulse.
- `level`  out  ADDR_WIDTH+1: number of stored entries, 0..16.
- `full`  out  1: `level` == 16.
- `empty`  out  1: `level` == 0.
- `overflow`  out  1: sticky; a write occurred while full.
- `end_pulse`  out  1: one-cycle pulse after the all-ones sample is accepted.
- `capturing`  out  1: FSM is in CAPTURE.

## Operation
- **FSM states:** IDLE, CAPTURE, STOPPED.
  - IDLE → CAPTURE on `start`.
  - CAPTURE → STOPPED when a sample equal to 2^DATA_WIDTH−1 is accepted.
  - Any state → IDLE on `clr`.
  - `start` in CAPTURE or STOPPED is ignored.
- **Write acceptance:** a write is accepted iff the state is CAPTURE and `in_valid` is high. Inputs are ignored in IDLE and STOPPED.
- **Write:** stores at `wr_ptr`; `wr_ptr` increments modulo 16 and wraps 15 → 0.
- **Read:** when `rd_req` is high and `level` > 0, the entry at `rd_ptr` goes to `rd_data` and `rd_ptr` increments modulo 16. `rd_req` while empty is ignored: `rd_valid` stays 0 and `rd_data` holds its value.
- **Reads are allowed in every state.** Draining after STOPPED is the normal use.
- **Simultaneous read and write:**
  - Not full and not empty: both complete and `level` is unchanged.
  - Empty: only the write completes; there is no fall-through.
  - Full: both complete and `level` stays 16. `overflow` is not set.
- **Write while full with no read:** behaviour is set by the macro in Configuration. `overflow` is set in either build.
- **`clr`:** zeroes both pointers, `level`, `overflow`, `end_pulse` and `rd_valid`. It does not erase memory contents, and `rd_data` holds its value.
- **Level arithmetic:** `level` is ADDR_WIDTH+1 bits wide and never exceeds 16.

## Timing
- **Reset values:** `rd_data`=0, `rd_valid`=0, `level`=0, `full`=0, `empty`=1, `overflow`=0, `end_pulse`=0, `capturing`=0; state is IDLE; pointers are 0.
- **Reset mid-operation:** takes effect immediately and asynchronously; pending reads and writes are lost.
- **Write latency:** a sample accepted at edge N is visible in `level`, `full` and `empty` after edge N.
- **Read latency:** `rd_req` sampled at edge N gives `rd_data`/`rd_valid` valid after edge N, for one cycle.
- **`end_pulse`:** high for exactly the cycle after the edge that accepted 255. `capturing` falls on that same edge.
- **`start`:** `start` at edge N enables acceptance from edge N+1 onward.
- **Flag update:** `full`, `empty` and `overflow` are registered or derived from registered `level`, with no combinational path from inputs.

## Configuration
- **`COUNT_RECORDER_OVERWRITE_EN` defined:** a write while full with no read overwrites the oldest entry. Both `wr_ptr` and `rd_ptr` advance, `level` stays 16, and the buffer holds the newest 16 samples.
- **Macro undefined (default):** a write while full with no read is dropped. Pointers and memory are unchanged, and the buffer keeps the oldest 16 samples.
- `overflow` sets identically in both builds.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle while `level`=5 → all outputs return to their reset values immediately; `empty`=1.
- **Basic capture and drain:** `start`, then write 0..9 with `in_valid`, then `rd_req` ×10 → `rd_data` 0..9 in order, one `rd_valid` per cycle after each request; `empty`=1 at the end.
- **End of count:** after `start`, feed 250..255 → `end_pulse` high for one cycle after the 255 write; `capturing`=0; a following sample 0 is not stored; `level`=6.
- **Full without overwrite (macro undefined):** write 0..19 → `full`=1, `overflow`=1, `level`=16; drain returns 0..15.
- **Full with overwrite (macro defined):** same stimulus as the previous scenario → drain returns 4..19, `overflow`=1; pointer wrap 15→0 is exercised.
- **Simultaneous read/write and clear:**
  - Read and write in the same cycle while `level`=16 → `level` stays 16, `overflow` stays 0.
  - Read and write in the same cycle while empty → `rd_valid`=0, `level`=1.
  - `clr` together with `in_valid` → `level`=0, state IDLE, `overflow`=0.
